// File: rtl/router_input_port_pkg.sv
// Shared types and constants for the mesh router ingress port: AXIS flit structs,
// header TID, output lane indices and header field layout.
package router_input_port_pkg;

  localparam int AXIS_DATA_WIDTH = 40;
  localparam int AXIS_TID_WIDTH  = 2;

  typedef struct packed {
    logic                       tvalid;
    logic [AXIS_TID_WIDTH-1:0]  tid;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  localparam logic [AXIS_TID_WIDTH-1:0] ROUTING_HEADER = 2'd1;

  localparam int LANE_LOCAL = 0;
  localparam int LANE_N     = 1;
  localparam int LANE_E     = 2;
  localparam int LANE_S     = 3;
  localparam int LANE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } rip_state_e;

  // Body length byte sits just above a second (x,y) coordinate pair.
  function automatic int hdr_len_lsb(input int x_w, input int y_w);
    return 2 * (x_w + y_w);
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Handshake bundle of one router input port: ingress AXIS link, the per-arbiter
// output lanes and the packet status flags.
interface router_input_port_if #(
  parameter int CHANNEL_NUMBER = 5
);
  import router_input_port_pkg::*;

  localparam int CH_W = $clog2(CHANNEL_NUMBER);

  axis_mosi_t                      in_mosi_i;
  axis_miso_t                      in_miso_o;
  axis_mosi_t [CHANNEL_NUMBER-1:0] out_mosi_o;
  axis_miso_t [CHANNEL_NUMBER-1:0] out_miso_i;
  logic                            busy_o;
  logic [CH_W-1:0]                 route_o;
  logic                            drop_o;

  modport slave (
    input  in_mosi_i, out_miso_i,
    output in_miso_o, out_mosi_o, busy_o, route_o, drop_o
  );

  modport master (
    output in_mosi_i, out_miso_i,
    input  in_miso_o, out_mosi_o, busy_o, route_o, drop_o
  );

endinterface

// File: rtl/router_input_port_fifo.sv
// Synchronous FIFO, head visible combinationally, one cycle write-to-read latency.
// Push is ignored when full and pop when empty; full/empty come from a registered count.
module axis_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/router_input_port.sv
// Router ingress: buffers flits, XY-routes each packet and locks one output lane until the body is sent.
// Input to output takes at least 2 cycles; input TREADY drops only when the buffer is full.
module router_input_port
  import router_input_port_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 5,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  parameter int BUFFER_DEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  router_input_port_if.slave   bus
);

  localparam int X_W     = $clog2(MAX_ROUTERS_X);
  localparam int Y_W     = $clog2(MAX_ROUTERS_Y);
  localparam int CH_W    = $clog2(CHANNEL_NUMBER);
  localparam int LEN_LSB = hdr_len_lsb(X_W, Y_W);
  localparam int FIFO_W  = AXIS_TID_WIDTH + AXIS_DATA_WIDTH;

  localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

  rip_state_e                      r_state;
  rip_state_e                      w_state_nxt;
  logic [CH_W-1:0]                 r_route;
  logic [7:0]                      r_flits_left;

  logic                            w_in_rdy;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_full;
  logic                            w_empty;
  logic [FIFO_W-1:0]               w_head;
  logic [AXIS_TID_WIDTH-1:0]       w_head_tid;
  logic [AXIS_DATA_WIDTH-1:0]      w_head_dat;
  logic                            w_is_hdr;
  logic [X_W-1:0]                  w_tx;
  logic [Y_W-1:0]                  w_ty;
  logic [7:0]                      w_len;
  logic [CH_W-1:0]                 w_route_dec;
  logic                            w_lane_rdy;
  logic                            w_xfer;
  logic                            w_drop;
  logic                            w_busy;
  axis_mosi_t [CHANNEL_NUMBER-1:0] w_lanes;

  // TREADY is held low while reset is applied so nothing is enqueued into a flushing buffer.
  assign w_in_rdy = !w_full && !rst_i;
  assign w_push   = bus.in_mosi_i.tvalid && w_in_rdy;

  axis_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   ({bus.in_mosi_i.tid, bus.in_mosi_i.tdata}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign {w_head_tid, w_head_dat} = w_head;
  assign w_is_hdr = (w_head_tid == ROUTING_HEADER);
  assign w_ty     = w_head_dat[Y_W-1:0];
  assign w_tx     = w_head_dat[X_W+Y_W-1:Y_W];
  assign w_len    = w_head_dat[LEN_LSB+7:LEN_LSB];

  always_comb begin
    w_route_dec = CH_W'(LANE_LOCAL);
    if (w_tx > RX)      w_route_dec = CH_W'(LANE_E);
    else if (w_tx < RX) w_route_dec = CH_W'(LANE_W);
    else if (w_ty > RY) w_route_dec = CH_W'(LANE_N);
    else if (w_ty < RY) w_route_dec = CH_W'(LANE_S);
  end

  always_comb begin
    w_lane_rdy = 1'b0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (r_route == CH_W'(i)) w_lane_rdy = bus.out_miso_i[i].tready;
    end
  end

  assign w_xfer = (r_state != ST_IDLE) && !w_empty && w_lane_rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty && w_is_hdr) w_state_nxt = ST_HEAD;
      ST_HEAD: if (w_xfer) w_state_nxt = (r_flits_left == 8'd0) ? ST_IDLE : ST_BODY;
      ST_BODY: if (w_xfer && r_flits_left == 8'd1) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_lanes = '0;
    w_pop   = 1'b0;
    w_drop  = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !w_is_hdr) begin
          w_pop  = 1'b1;
          w_drop = 1'b1;
        end
      end
      ST_HEAD, ST_BODY: begin
        w_busy = 1'b1;
        w_pop  = w_xfer;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
          if (r_route == CH_W'(i)) begin
            w_lanes[i].tvalid = !w_empty;
            w_lanes[i].tid    = w_head_tid;
            w_lanes[i].tdata  = w_head_dat;
          end
        end
      end
      default: ;
    endcase
  end

  // Route and length are captured once per packet; embedded header TIDs in the body are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_route      <= '0;
      r_flits_left <= '0;
    end else if (r_state == ST_IDLE && !w_empty && w_is_hdr) begin
      r_route      <= w_route_dec;
      r_flits_left <= w_len;
    end else if (r_state == ST_BODY && w_xfer) begin
      r_flits_left <= r_flits_left - 8'd1;
    end
  end

  assign bus.in_miso_o.tready = w_in_rdy;
  assign bus.out_mosi_o       = w_lanes;
  assign bus.busy_o           = w_busy;
  assign bus.route_o          = r_route;
  assign bus.drop_o           = w_drop;

endmodule

// File: tb/tb_router_input_port.sv
// Self-checking bench for router_input_port at mesh position (1,1) with a 4-entry buffer.
// Expected lane streams come from a packet-level model of the routing rules.
module tb_router_input_port;
  import router_input_port_pkg::*;

  localparam logic [1:0] RH = ROUTING_HEADER;

  typedef struct { logic [1:0] tid; logic [39:0] dat; } flit_t;
  typedef struct { int lane; logic [1:0] tid; logic [39:0] dat; int c; } obs_t;
  typedef struct { int tx; int ty; int len; int lane; } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_input_port_if #(.CHANNEL_NUMBER(5)) bus();

  router_input_port #(
    .CHANNEL_NUMBER(5), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
    .ROUTER_X(1), .ROUTER_Y(1), .BUFFER_DEPTH(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vecs = 0, bad = 0, cyc = 0, drops = 0, multi_err = 0, route_err = 0;
  int n_acc = 0, first_acc = 0, ob0 = 0, dr0 = 0, exp_drops = 0;
  logic [4:0] rdy_mask = '0, rnd_bits = '0;
  logic rnd_rdy = 1'b0;
  flit_t stim[$];
  obs_t  obs[$];
  obs_t  exp_q[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rnd_bits <= 5'($urandom()) | 5'($urandom());
  end

  always_comb begin
    for (int i = 0; i < 5; i++) bus.out_miso_i[i].tready = rnd_rdy ? rnd_bits[i] : rdy_mask[i];
  end

  // Transfer monitor: values seen at the falling edge are what the next rising edge commits.
  always @(negedge clk) begin
    int nv;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_mosi_o[i].tvalid) begin
        nv++;
        if (!bus.busy_o || bus.route_o != 3'(i)) route_err++;
        if (bus.out_miso_i[i].tready)
          obs.push_back('{lane: i, tid: bus.out_mosi_o[i].tid, dat: bus.out_mosi_o[i].tdata, c: cyc});
      end
    end
    if (nv > 1) multi_err++;
    if (bus.drop_o) drops++;
  end

  task automatic check(input string nm, input longint act, input longint req);
    vecs++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  function automatic logic [39:0] hdr(input int tx, input int ty, input int len);
    logic [39:0] d;
    d = rnd40();
    d[1:0]  = 2'(ty);
    d[3:2]  = 2'(tx);
    d[15:8] = 8'(len);
    return d;
  endfunction

  // XY dimension-order rule for a router sitting at column 1, row 1.
  function automatic int xy_lane(input logic [39:0] d);
    int tx, ty;
    tx = int'(d[3:2]);
    ty = int'(d[1:0]);
    if (tx > 1) return 2;
    if (tx < 1) return 4;
    if (ty > 1) return 1;
    if (ty < 1) return 3;
    return 0;
  endfunction

  task automatic build_model();
    int i, lane, len;
    exp_q.delete();
    exp_drops = 0;
    i = 0;
    while (i < stim.size()) begin
      if (stim[i].tid != RH) begin
        exp_drops++;
        i++;
      end else begin
        lane = xy_lane(stim[i].dat);
        len  = int'(stim[i].dat[15:8]);
        for (int k = 0; k <= len && i < stim.size(); k++) begin
          exp_q.push_back('{lane: lane, tid: stim[i].tid, dat: stim[i].dat, c: 0});
          i++;
        end
      end
    end
  endtask

  task automatic clear();
    stim.delete();
    ob0   = obs.size();
    dr0   = drops;
    n_acc = 0;
  endtask

  task automatic push_flit(input flit_t f);
    int n;
    n = 0;
    bus.in_mosi_i = '{tvalid: 1'b1, tid: f.tid, tdata: f.dat};
    @(negedge clk);
    while (!bus.in_miso_o.tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_timeout", longint'(n), 0);
    else begin
      if (n_acc == 0) first_acc = cyc;
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.in_mosi_i = '0;
  endtask

  task automatic send_all(input int gap_max);
    for (int i = 0; i < stim.size(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
      push_flit(stim[i]);
    end
  endtask

  task automatic wait_obs(input int n);
    int k;
    k = 0;
    while (obs.size() - ob0 < n && k < 5000) begin
      step();
      k++;
    end
    if (obs.size() - ob0 < n) check("wait_obs_timeout", longint'(obs.size() - ob0), longint'(n));
  endtask

  task automatic compare_stream(input string nm);
    int n;
    n = obs.size() - ob0;
    check($sformatf("%s_count", nm), longint'(n), longint'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check($sformatf("%s_lane%0d", nm, i), longint'(obs[ob0+i].lane), longint'(exp_q[i].lane));
      check($sformatf("%s_tid%0d", nm, i), longint'(obs[ob0+i].tid), longint'(exp_q[i].tid));
      check($sformatf("%s_dat%0d", nm, i), longint'(obs[ob0+i].dat), longint'(exp_q[i].dat));
    end
    check($sformatf("%s_drops", nm), longint'(drops - dr0), longint'(exp_drops));
  endtask

  initial begin
    vec_t tbl[8];
    int len;
    logic [1:0] t;

    tbl = '{'{3, 0, 0, 2}, '{2, 3, 1, 2}, '{0, 3, 0, 4}, '{0, 0, 2, 4},
            '{1, 2, 0, 1}, '{1, 3, 1, 1}, '{1, 0, 0, 3}, '{1, 1, 1, 0}};

    // Reset state
    rst = 1'b1;
    bus.in_mosi_i = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_tready", bus.in_miso_o.tready, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_route", bus.route_o, 0);
    check("rst_drop", bus.drop_o, 0);
    check("rst_lanes_zero", longint'(bus.out_mosi_o == '0), 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", bus.in_miso_o.tready, 1);
    step();

    // Route decode table
    rdy_mask = '1;
    for (int v = 0; v < 8; v++) begin
      clear();
      stim.push_back('{RH, hdr(tbl[v].tx, tbl[v].ty, tbl[v].len)});
      for (int k = 0; k < tbl[v].len; k++) stim.push_back('{2'd0, rnd40()});
      send_all(0);
      wait_obs(tbl[v].len + 1);
      step();
      for (int i = 0; i <= tbl[v].len && ob0 + i < obs.size(); i++)
        check($sformatf("tbl%0d_lane%0d", v, i), longint'(obs[ob0+i].lane), longint'(tbl[v].lane));
      if (obs.size() > ob0) check($sformatf("tbl%0d_hdr", v), longint'(obs[ob0].dat), longint'(stim[0].dat));
    end

    // Lane isolation, latency and busy timing
    clear();
    stim.push_back('{RH, hdr(3, 0, 2)});
    stim.push_back('{2'd0, rnd40()});
    stim.push_back('{2'd2, rnd40()});
    build_model();
    send_all(0);
    wait_obs(3);
    if (obs.size() > ob0) check("A_latency", longint'(obs[ob0].c - first_acc), 2);
    @(negedge clk);
    check("A_busy_fall", bus.busy_o, 0);
    compare_stream("A");
    step();

    // Header-only packet followed by a local packet after one bubble
    clear();
    stim.push_back('{RH, hdr(1, 2, 0)});
    stim.push_back('{RH, hdr(1, 1, 1)});
    stim.push_back('{2'd3, rnd40()});
    build_model();
    send_all(0);
    wait_obs(3);
    repeat (3) step();
    compare_stream("B");
    if (obs.size() > ob0 + 1) check("B_bubble", longint'(obs[ob0+1].c - obs[ob0].c), 2);

    // Backpressure on the west lane with a 6-flit packet
    clear();
    rdy_mask = '0;
    stim.push_back('{RH, hdr(0, 2, 5)});
    for (int k = 0; k < 5; k++) stim.push_back('{2'd0, rnd40()});
    build_model();
    fork
      send_all(0);
      begin
        repeat (10) step();
        @(negedge clk);
        check("C_accepted", longint'(n_acc), 4);
        check("C_tready_low", bus.in_miso_o.tready, 0);
        check("C_vld_held", bus.out_mosi_o[4].tvalid, 1);
        step();
        rdy_mask = '1;
      end
    join
    wait_obs(6);
    repeat (3) step();
    compare_stream("C");

    // Orphan body flit in IDLE
    clear();
    stim.push_back('{2'd0, rnd40()});
    stim.push_back('{RH, hdr(2, 1, 1)});
    stim.push_back('{2'd0, rnd40()});
    build_model();
    send_all(0);
    wait_obs(2);
    repeat (3) step();
    compare_stream("D");

    // Source gap after the header and a header-tagged body flit
    clear();
    stim.push_back('{RH, hdr(1, 0, 3)});
    stim.push_back('{2'd0, rnd40()});
    stim.push_back('{RH, hdr(3, 3, 7)});
    stim.push_back('{2'd2, rnd40()});
    build_model();
    push_flit(stim[0]);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("E_route_gap%0d", k), bus.route_o, 3);
      check($sformatf("E_busy_gap%0d", k), bus.busy_o, 1);
      step();
    end
    for (int i = 1; i < 4; i++) push_flit(stim[i]);
    wait_obs(4);
    repeat (6) step();
    @(negedge clk);
    check("E_busy_end", bus.busy_o, 0);
    compare_stream("E");
    step();

    // Reset in BODY with two flits still buffered
    clear();
    rdy_mask = '0;
    stim.push_back('{RH, hdr(0, 1, 4)});
    stim.push_back('{2'd0, rnd40()});
    stim.push_back('{2'd0, rnd40()});
    send_all(0);
    step();
    rdy_mask = 5'b10000;
    step();
    rdy_mask = '0;
    @(negedge clk);
    check("F_body_busy", bus.busy_o, 1);
    check("F_body_route", bus.route_o, 4);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("F_tready_in_rst", bus.in_miso_o.tready, 0);
    step();
    rst = 1'b0;
    rdy_mask = '1;
    @(negedge clk);
    check("F_post_busy", bus.busy_o, 0);
    check("F_post_route", bus.route_o, 0);
    check("F_post_drop", bus.drop_o, 0);
    check("F_post_lanes_zero", longint'(bus.out_mosi_o == '0), 1);
    step();
    clear();
    stim.push_back('{RH, hdr(1, 1, 0)});
    build_model();
    send_all(0);
    wait_obs(1);
    repeat (3) step();
    compare_stream("F");

    // Randomized packet stream with random output readiness and input gaps
    clear();
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 4) == 0) begin
        t = 2'($urandom_range(0, 2));
        if (t == RH) t = 2'd3;
        stim.push_back('{t, rnd40()});
      end
      len = $urandom_range(0, 5);
      stim.push_back('{RH, hdr($urandom_range(0, 3), $urandom_range(0, 3), len)});
      for (int k = 0; k < len; k++) begin
        t = ($urandom_range(0, 5) == 0) ? RH : 2'($urandom_range(0, 3));
        stim.push_back('{t, rnd40()});
      end
    end
    build_model();
    rnd_rdy = 1'b1;
    send_all(2);
    wait_obs(exp_q.size());
    rnd_rdy = 1'b0;
    repeat (10) step();
    compare_stream("R");

    check("one_lane_at_a_time", longint'(multi_err), 0);
    check("lane_matches_route", longint'(route_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
